regfile_2r1w: RTL and testbench

- Parametrised general-purpose register file for the MIPS datapath.
- Two combinational read ports and one clocked write port.
- Entry 0 is optionally hardwired to zero.
- Storage uses N instances of a generic width-parametrised enabled register; it generalises the fixed 32-bit enabled register into an addressable array.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/reg_en_n.sv | 19 +
 rtl/regfile_2r1w.sv | 67 ++++++
 tb/tb_regfile_2r1w.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the two-read/one-write register file.
package regfile_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_ADDR      = 0;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_en_n.sv
// Width-parametrised register with load enable and asynchronous active-high clear.
module reg_en_n #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clk,
    input  logic             reset,
    input  logic             en
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_out <= '0;
        else if (en)
            data_out <= data_in;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one clocked write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] entry_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG != 0 && i == ZERO_ADDR) begin : g_zero
            assign entry_q[i] = '0;
        end else begin : g_reg
            // Only in-range addresses can match, so out-of-range writes enable nothing.
            logic en;
            assign en = we && (waddr == ADDR_W'(i));

            reg_en_n #(.WIDTH(WIDTH)) u_reg (
                .data_out (entry_q[i]),
                .data_in  (wdata),
                .clk      (clk),
                .reset    (reset),
                .en       (en)
            );
        end
    end

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    logic wr_legal;
    assign wr_legal = we && !reset && ({1'b0, waddr} < DEPTH_A) &&
                      !(ZERO_REG != 0 && waddr == ADDR_W'(ZERO_ADDR));
`endif

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == ADDR_W'(i))
                rdata_a = entry_q[i];
            if (raddr_b == ADDR_W'(i))
                rdata_b = entry_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_legal && waddr == raddr_a)
            rdata_a = wdata;
        if (wr_legal && waddr == raddr_b)
            rdata_b = wdata;
`endif
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench: default, ZERO_REG=0 and DEPTH=24 instances share stimulus.
`timescale 1ns/1ps
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    word_t       wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    word_t       rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;

    int errors = 0;
    int checks = 0;

    regfile_2r1w dut0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a0), .raddr_b(raddr_b), .rdata_b(rd_b0)
    );

    regfile_2r1w #(.ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a1), .raddr_b(raddr_b), .rdata_b(rd_b1)
    );

    regfile_2r1w #(.DEPTH(24), .ADDR_W(5)) dut2 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a2), .raddr_b(raddr_b), .rdata_b(rd_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] addr, input word_t data);
        @(negedge clk);
        we    = 1'b1;
        waddr = addr;
        wdata = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = 5'd5;
        raddr_b = 5'd5;
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        checks++;
        if (rd_a0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_during_write: rdata_a=%h expected=%h", rd_a0, 32'h0);
        end
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_a0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_lost: rdata_a=%h expected=%h", rd_a0, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #0.1;
            checks++;
            if (rd_a0 !== 32'h0 || rd_b0 !== 32'h0 || rd_a1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_all_zero[%0d]: a0=%h b0=%h a1=%h expected=0", i, rd_a0, rd_b0, rd_a1);
            end
        end
    endtask

    task automatic test_write();
        do_write(5'd7, 32'h12345678);
        raddr_a = 5'd7;
        raddr_b = 5'd7;
        #1;
        checks++;
        if (rd_a0 !== 32'h12345678 || rd_b0 !== 32'h12345678) begin
            errors++;
            $display("FAIL write_both_ports: a=%h b=%h expected=%h", rd_a0, rd_b0, 32'h12345678);
        end
        raddr_a = 5'd6;
        raddr_b = 5'd8;
        #1;
        checks++;
        if (rd_a0 !== 32'h0 || rd_b0 !== 32'h0) begin
            errors++;
            $display("FAIL write_neighbours: a(6)=%h b(8)=%h expected=0", rd_a0, rd_b0);
        end
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd7;
        wdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        raddr_a = 5'd7;
        #1;
        checks++;
        if (rd_a0 !== 32'h12345678) begin
            errors++;
            $display("FAIL we_low_hold: rdata_a=%h expected=%h", rd_a0, 32'h12345678);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFFFFFF);
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (rd_a0 !== 32'h0 || rd_b0 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_on: a=%h b=%h expected=0", rd_a0, rd_b0);
        end
        checks++;
        if (rd_a1 !== 32'hFFFFFFFF || rd_b1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_reg_off: a=%h b=%h expected=%h", rd_a1, rd_b1, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_read_during_write();
        word_t exp_before;
        do_write(5'd3, 32'h11);
`ifdef REGFILE_BYPASS_EN
        exp_before = 32'h22;
`else
        exp_before = 32'h11;
`endif
        @(negedge clk);
        we      = 1'b1;
        waddr   = 5'd3;
        wdata   = 32'h22;
        raddr_a = 5'd3;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (rd_a0 !== exp_before) begin
            errors++;
            $display("FAIL rdw_before_edge: rdata_a=%h expected=%h", rd_a0, exp_before);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        checks++;
        if (rd_a0 !== 32'h22) begin
            errors++;
            $display("FAIL rdw_after_edge: rdata_a=%h expected=%h", rd_a0, 32'h22);
        end
        // Forwarding must never apply to the hardwired zero entry.
        @(negedge clk);
        we      = 1'b1;
        waddr   = 5'd0;
        wdata   = 32'h33;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (rd_b0 !== 32'h0) begin
            errors++;
            $display("FAIL rdw_zero_entry: rdata_b=%h expected=0", rd_b0);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 32; i++)
            do_write(5'(i), 32'(i) * 32'h01010101);
        raddr_a = 5'd31;
        raddr_b = 5'd12;
        #1;
        checks++;
        if (rd_a0 !== 32'h1F1F1F1F || rd_b0 !== 32'h0C0C0C0C) begin
            errors++;
            $display("FAIL fill_readback: a(31)=%h b(12)=%h expected=1f1f1f1f/0c0c0c0c", rd_a0, rd_b0);
        end
        @(negedge clk);
        #0.5;
        reset = 1'b1;
        for (int i = 1; i < 32; i += 5) begin
            raddr_a = 5'(i);
            raddr_b = 5'(32 - i);
            #0.2;
            checks++;
            if (rd_a0 !== 32'h0 || rd_b0 !== 32'h0) begin
                errors++;
                $display("FAIL async_reset[%0d]: a=%h b=%h expected=0", i, rd_a0, rd_b0);
            end
        end
        reset = 1'b0;
        do_write(5'd9, 32'hA5);
        raddr_a = 5'd9;
        raddr_b = 5'd31;
        #1;
        checks++;
        if (rd_a0 !== 32'hA5 || rd_b0 !== 32'h0) begin
            errors++;
            $display("FAIL write_after_reset: a(9)=%h b(31)=%h expected=000000a5/0", rd_a0, rd_b0);
        end
    endtask

    task automatic test_depth();
        do_write(5'd28, 32'hCAFE);
        raddr_a = 5'd9;
        raddr_b = 5'd28;
        #1;
        checks++;
        if (rd_b2 !== 32'h0) begin
            errors++;
            $display("FAIL depth_oob_read: rdata_b(28)=%h expected=0", rd_b2);
        end
        checks++;
        if (rd_a2 !== 32'hA5) begin
            errors++;
            $display("FAIL depth_inrange_keep: rdata_a(9)=%h expected=%h", rd_a2, 32'hA5);
        end
        for (int i = 0; i < 24; i++) begin
            raddr_a = 5'(i);
            #0.1;
            checks++;
            if (rd_a2 !== ((i == 9) ? 32'hA5 : 32'h0)) begin
                errors++;
                $display("FAIL depth_no_alias[%0d]: rdata_a=%h", i, rd_a2);
            end
        end
        raddr_b = 5'd28;
        #1;
        checks++;
        if (rd_b0 !== 32'hCAFE) begin
            errors++;
            $display("FAIL full_depth_write28: rdata_b=%h expected=%h", rd_b0, 32'hCAFE);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_read_during_write();
        test_reset_mid();
        test_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
